// File: rtl/mem_port_arbiter.sv
// Two-port round-robin front end for the shared 256-byte data memory.
// Optional odd-address trap is enabled by defining MEM_ARB_ALIGN_CHK_EN.

module mem_port_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,

   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,

   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              win_q, win_d;
   logic              wr_q, wr_d;
   logic              mis_q, mis_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic              any_req;
   logic              win;
   logic              w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic              mis;

   // On a tie the port that did not win last time gets the slot
   assign any_req = req0 | req1;
   assign win     = (req0 & req1) ? ~last_q : req1;
   assign w_we    = win ? we1    : we0;
   assign w_addr  = win ? addr1  : addr0;
   assign w_wdata = win ? wdata1 : wdata0;

`ifdef MEM_ARB_ALIGN_CHK_EN
   assign mis = w_addr[0];
`else
   assign mis = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      win_d       = win_q;
      wr_d        = wr_q;
      mis_d       = mis_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      err_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d     = ACCESS;
               last_d      = win;
               win_d       = win;
               wr_d        = w_we;
               mis_d       = mis;
               gnt0_d      = ~win;
               gnt1_d      = win;
               mem_addr_d  = w_addr;
               mem_wdata_d = w_wdata;
               mem_read_d  = ~w_we & ~mis;
               mem_write_d = w_we & ~mis;
               err_d       = mis;
            end
         end
         ACCESS: begin
            state_d = (wr_q | mis_q) ? IDLE : RESP;
         end
         RESP: begin
            state_d = IDLE;
            if (win_q) begin
               rvalid1_d = 1'b1;
               rdata1_d  = mem_rdata;
            end else begin
               rvalid0_d = 1'b1;
               rdata0_d  = mem_rdata;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         win_q       <= 1'b0;
         wr_q        <= 1'b0;
         mis_q       <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         win_q       <= win_d;
         wr_q        <= wr_d;
         mis_q       <= mis_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign rvalid0   = rvalid0_q;
   assign rvalid1   = rvalid1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a big-endian byte memory model.
// Build with MEM_ARB_ALIGN_CHK_EN to exercise the odd-address trap.

module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        req0, we0, req1, we1;
   logic [7:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [15:0] rdata0, rdata1;
   logic        mem_read, mem_write;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        busy, err;

   logic [7:0]  mem [0:255];

   int passes;
   int total;
   int g, cyc, r0cnt, r1cnt;
   int order [4];
   logic bad0, bad1, ovl, stray;

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: samples the command on the edge, read data valid next cycle
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[0] = 8'h2B; mem[1] = 8'hCD;
      mem[4] = 8'h12; mem[5] = 8'h34;
      mem[6] = 8'hDE; mem[7] = 8'hAD;
      mem[8] = 8'h55; mem[9] = 8'h66;
      mem[255] = 8'h77;
      mem_rdata = 16'h0000;
      forever begin
         @(posedge clk);
         if (mem_write) begin
            mem[mem_addr]        = mem_wdata[15:8];
            mem[mem_addr + 8'd1] = mem_wdata[7:0];
         end
         if (mem_read)
            mem_rdata <= {mem[mem_addr], mem[mem_addr + 8'd1]};
      end
   end

   task automatic chk1(input string tag, input logic o, input logic e);
      total = total + 1;
      assert (o === e) passes = passes + 1;
      else $error("FAIL %s: got %0h want %0h", tag, o, e);
   endtask

   task automatic chk8(input string tag, input logic [7:0] o,
                       input logic [7:0] e);
      total = total + 1;
      assert (o === e) passes = passes + 1;
      else $error("FAIL %s: got %0h want %0h", tag, o, e);
   endtask

   task automatic chk16(input string tag, input logic [15:0] o,
                        input logic [15:0] e);
      total = total + 1;
      assert (o === e) passes = passes + 1;
      else $error("FAIL %s: got %0h want %0h", tag, o, e);
   endtask

   task automatic chki(input string tag, input int o, input int e);
      total = total + 1;
      assert (o === e) passes = passes + 1;
      else $error("FAIL %s: got %0d want %0d", tag, o, e);
   endtask

   task automatic set_req(input int p, input logic r, input logic w,
                          input logic [7:0] a, input logic [15:0] d);
      if (p == 0) begin
         req0 = r; we0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = r; we1 = w; addr1 = a; wdata1 = d;
      end
   endtask

   // Single-port transaction from IDLE, checked cycle by cycle
   task automatic txn(input int p, input logic w, input logic [7:0] a,
                      input logic [15:0] d, input logic [15:0] exp_rd);
      int n;
      logic got;
      n = 0;
      got = 1'b0;
      set_req(p, 1'b1, w, a, d);
      while (!got && n < 12) begin
         @(negedge clk);
         n++;
         if ((p == 1) ? gnt1 : gnt0) got = 1'b1;
      end
      chki("gnt_latency", n, 1);
      chk1("other_gnt", (p == 1) ? gnt0 : gnt1, 1'b0);
      chk8("mem_addr", mem_addr, a);
      chk1("mem_read_at_gnt", mem_read, !w);
      chk1("mem_write_at_gnt", mem_write, w);
      if (w) chk16("mem_wdata", mem_wdata, d);
      set_req(p, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge clk);
      chk1("gnt_one_cycle", (p == 1) ? gnt1 : gnt0, 1'b0);
      chk1("strobes_clear", mem_read | mem_write, 1'b0);
      if (!w) begin
         @(negedge clk);
         chk1("rvalid", (p == 1) ? rvalid1 : rvalid0, 1'b1);
         chk1("other_rvalid", (p == 1) ? rvalid0 : rvalid1, 1'b0);
         chk16("rdata", (p == 1) ? rdata1 : rdata0, exp_rd);
      end else begin
         chk1("write_no_rvalid", rvalid0 | rvalid1, 1'b0);
         chk1("write_busy_done", busy, 1'b0);
      end
   endtask

   initial begin
      passes = 0;
      total  = 0;
      reset  = 1'b1;
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      set_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      #2 reset = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk1("rst_gnt", gnt0 | gnt1, 1'b0);
      chk1("rst_rvalid", rvalid0 | rvalid1, 1'b0);
      chk1("rst_strobes", mem_read | mem_write, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk8("rst_mem_addr", mem_addr, 8'h00);
      chk16("rst_mem_wdata", mem_wdata, 16'h0000);
      chk16("rst_rdata0", rdata0, 16'h0000);
      chk16("rst_rdata1", rdata1, 16'h0000);
      reset = 1'b1;

      // Port 0 read of preloaded word
      txn(0, 1'b0, 8'h00, 16'h0000, 16'h2BCD);
      chk16("rdata1_untouched", rdata1, 16'h0000);
      chk1("busy_after_read", busy, 1'b0);
      @(negedge clk);
      chk1("rvalid0_pulse", rvalid0, 1'b0);

      // Port 1 write then read back
      txn(1, 1'b1, 8'h10, 16'hA55A, 16'h0000);
      txn(1, 1'b0, 8'h10, 16'h0000, 16'hA55A);

      // Both ports requesting continuously
      set_req(0, 1'b1, 1'b0, 8'h04, 16'h0000);
      set_req(1, 1'b1, 1'b0, 8'h06, 16'h0000);
      g = 0; cyc = 0; r0cnt = 0; r1cnt = 0;
      bad0 = 1'b0; bad1 = 1'b0; ovl = 1'b0;
      while (g < 4 && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (rvalid0 & rvalid1) ovl = 1'b1;
         if (mem_read & mem_write) ovl = 1'b1;
         if (gnt0 & gnt1) ovl = 1'b1;
         if (rvalid0) begin
            r0cnt++;
            if (rdata0 !== 16'h1234) bad0 = 1'b1;
         end
         if (rvalid1) begin
            r1cnt++;
            if (rdata1 !== 16'hDEAD) bad1 = 1'b1;
         end
         if (gnt0 | gnt1) begin
            order[g] = gnt1 ? 1 : 0;
            g++;
         end
      end
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      set_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (rvalid0 & rvalid1) ovl = 1'b1;
         if (rvalid0) begin
            r0cnt++;
            if (rdata0 !== 16'h1234) bad0 = 1'b1;
         end
         if (rvalid1) begin
            r1cnt++;
            if (rdata1 !== 16'hDEAD) bad1 = 1'b1;
         end
      end
      chki("rr_grants", g, 4);
      chki("rr_order0", order[0], 0);
      chki("rr_order1", order[1], 1);
      chki("rr_order2", order[2], 0);
      chki("rr_order3", order[3], 1);
      chki("rr_cycles", cyc, 10);
      chki("rr_rvalid0_cnt", r0cnt, 2);
      chki("rr_rvalid1_cnt", r1cnt, 2);
      chk1("rr_rdata0_bad", bad0, 1'b0);
      chk1("rr_rdata1_bad", bad1, 1'b0);
      chk1("rr_overlap", ovl, 1'b0);

      // Port 0 write arriving while port 1 read is in flight
      set_req(1, 1'b1, 1'b0, 8'h04, 16'h0000);
      @(negedge clk);
      chk1("inflight_gnt1", gnt1, 1'b1);
      set_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      set_req(0, 1'b1, 1'b1, 8'h20, 16'hBEEF);
      @(negedge clk);
      chk1("inflight_no_gnt0_a", gnt0, 1'b0);
      chk1("inflight_no_wr_a", mem_write, 1'b0);
      @(negedge clk);
      chk1("inflight_no_gnt0_b", gnt0, 1'b0);
      chk1("inflight_rvalid1", rvalid1, 1'b1);
      chk16("inflight_rdata1", rdata1, 16'h1234);
      @(negedge clk);
      chk1("inflight_gnt0", gnt0, 1'b1);
      chk1("inflight_wr", mem_write, 1'b1);
      chk1("inflight_rd_low", mem_read, 1'b0);
      chk8("inflight_addr", mem_addr, 8'h20);
      chk16("inflight_wdata", mem_wdata, 16'hBEEF);
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge clk);
      chk1("inflight_wr_done", mem_write, 1'b0);
      txn(0, 1'b0, 8'h20, 16'h0000, 16'hBEEF);

`ifdef MEM_ARB_ALIGN_CHK_EN
      set_req(0, 1'b1, 1'b0, 8'h03, 16'h0000);
      @(negedge clk);
      chk1("mis_gnt0", gnt0, 1'b1);
      chk1("mis_err", err, 1'b1);
      chk1("mis_no_rd", mem_read, 1'b0);
      chk1("mis_no_wr", mem_write, 1'b0);
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge clk);
      chk1("mis_err_pulse", err, 1'b0);
      chk1("mis_idle", busy, 1'b0);
      chk1("mis_no_rd_b", mem_read, 1'b0);
      @(negedge clk);
      chk1("mis_no_rvalid", rvalid0, 1'b0);
      txn(0, 1'b0, 8'h02, 16'h0000, 16'h0000);
`else
      txn(0, 1'b0, 8'h03, 16'h0000, 16'h0012);
      chk1("odd_no_err", err, 1'b0);
      txn(1, 1'b0, 8'hFF, 16'h0000, 16'h772B);
      txn(0, 1'b0, 8'h02, 16'h0000, 16'h0000);
`endif

      // Reset in the middle of a port 0 read
      set_req(0, 1'b1, 1'b0, 8'h08, 16'h0000);
      @(negedge clk);
      chk1("mid_gnt0", gnt0, 1'b1);
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge clk);
      chk1("mid_busy", busy, 1'b1);
      #1 reset = 1'b0;
      #1;
      chk1("mid_gnt", gnt0 | gnt1, 1'b0);
      chk1("mid_rvalid", rvalid0 | rvalid1, 1'b0);
      chk1("mid_strobes", mem_read | mem_write, 1'b0);
      chk1("mid_busy_clr", busy, 1'b0);
      chk1("mid_err", err, 1'b0);
      chk8("mid_mem_addr", mem_addr, 8'h00);
      chk16("mid_mem_wdata", mem_wdata, 16'h0000);
      chk16("mid_rdata0", rdata0, 16'h0000);
      chk16("mid_rdata1", rdata1, 16'h0000);
      @(negedge clk);
      reset = 1'b1;
      stray = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (rvalid0 | rvalid1 | mem_read | mem_write | busy) stray = 1'b1;
      end
      chk1("mid_no_stray", stray, 1'b0);
      set_req(0, 1'b1, 1'b0, 8'h00, 16'h0000);
      set_req(1, 1'b1, 1'b0, 8'h06, 16'h0000);
      @(negedge clk);
      chk1("post_rst_tie_gnt0", gnt0, 1'b1);
      chk1("post_rst_tie_gnt1", gnt1, 1'b0);
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      set_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      chk1("post_rst_rvalid0", rvalid0, 1'b1);
      chk16("post_rst_rdata0", rdata0, 16'h2BCD);
      @(negedge clk);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
